// File: rtl/mem_access_stage.sv
// RV32I MEM stage: drives the data-memory req/ack bus, aligns load/store lanes and registers MEM/WB.
// Latency 1 cycle after ack (or after entry for non-memory ops); o_stall freezes upstream while ack is pending.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_mem_reg_write,
    input  logic        i_mem_mem_write,
    input  logic        i_mem_lsb,
    input  logic        i_mem_lsh,
    input  logic        i_mem_load_signext,
    input  logic [31:0] i_mem_data_mem,
    input  logic [31:0] i_mem_pc4,
    input  logic [31:0] i_mem_data_ex_wb,
    input  logic [4:0]  i_mem_rd,
    input  logic [1:0]  i_mem_select_data_wb,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_wb_reg_write,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_misalign,
    output logic        o_bus_err
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        drop_q, drop_nxt;
    logic        req;

    logic        is_load, mem_op, sz_byte, sz_half, misalign, rd_ok;
    logic [1:0]  ofs;
    logic [31:0] shifted, load_data, alu_or_pc;

    logic        wb_we_nxt, mis_nxt, berr_nxt;
    logic [4:0]  wb_rd_nxt;
    logic [31:0] wb_data_nxt;

    assign ofs       = i_mem_data_ex_wb[1:0];
    assign is_load   = (i_mem_select_data_wb == 2'b01);
    assign mem_op    = i_mem_mem_write | is_load;
    assign sz_byte   = i_mem_lsb;
    assign sz_half   = i_mem_lsh & ~i_mem_lsb;
    assign misalign  = mem_op & ((sz_half & ofs[0]) | (~sz_byte & ~sz_half & (ofs != 2'b00)));
    assign rd_ok     = i_mem_reg_write & (i_mem_rd != 5'd0);
    assign alu_or_pc = (i_mem_select_data_wb == 2'b10) ? i_mem_pc4 : i_mem_data_ex_wb;

    // Request fields come straight from EX/MEM; they stay stable because upstream is frozen while waiting.
    assign o_dmem_we   = i_mem_mem_write;
    assign o_dmem_addr = {i_mem_data_ex_wb[31:2], 2'b00};

    always_comb begin
        o_dmem_be    = 4'b1111;
        o_dmem_wdata = i_mem_data_mem;
        if (sz_byte) begin
            o_dmem_be    = 4'b0001 << ofs;
            o_dmem_wdata = {4{i_mem_data_mem[7:0]}};
        end else if (sz_half) begin
            o_dmem_be    = ofs[1] ? 4'b1100 : 4'b0011;
            o_dmem_wdata = {2{i_mem_data_mem[15:0]}};
        end
    end

    always_comb begin
        shifted   = i_dmem_rdata;
        load_data = i_dmem_rdata;
        if (sz_byte) begin
            shifted   = i_dmem_rdata >> {ofs, 3'b000};
            load_data = {{24{i_mem_load_signext & shifted[7]}}, shifted[7:0]};
        end else if (sz_half) begin
            shifted   = i_dmem_rdata >> {ofs[1], 4'b0000};
            load_data = {{16{i_mem_load_signext & shifted[15]}}, shifted[15:0]};
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        drop_nxt    = 1'b0;
        req         = 1'b0;
        wb_we_nxt   = 1'b0;
        wb_rd_nxt   = i_mem_rd;
        wb_data_nxt = alu_or_pc;
        mis_nxt     = 1'b0;
        berr_nxt    = 1'b0;
        if (state == IDLE) begin
            // drop_q marks the cycle after a timeout: the aborted op is still presented and must be skipped.
            if (drop_q) begin
                wb_we_nxt = 1'b0;
            end else if (!mem_op) begin
                wb_we_nxt = rd_ok;
            end else if (misalign) begin
                mis_nxt = 1'b1;
            end else begin
                req = 1'b1;
                if (i_dmem_ack) begin
                    wb_we_nxt   = rd_ok & ~i_mem_mem_write;
                    wb_data_nxt = load_data;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 8'd1;
                end
            end
        end else begin
            req = 1'b1;
            if (i_dmem_ack) begin
                wb_we_nxt   = rd_ok & ~i_mem_mem_write;
                wb_data_nxt = load_data;
                state_nxt   = IDLE;
                cnt_nxt     = 8'd0;
            end else if (cnt == TMO) begin
                berr_nxt  = 1'b1;
                drop_nxt  = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end else if (cnt != 8'hFF) begin
                cnt_nxt = cnt + 8'd1;
            end
        end
    end

    assign o_dmem_req = resetn & req;
    assign o_stall    = resetn & req & ~i_dmem_ack;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            drop_q         <= 1'b0;
            o_wb_reg_write <= 1'b0;
            o_wb_rd        <= 5'd0;
            o_wb_data      <= 32'd0;
            o_misalign     <= 1'b0;
            o_bus_err      <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            drop_q         <= drop_nxt;
            o_wb_reg_write <= wb_we_nxt;
            o_wb_rd        <= wb_rd_nxt;
            o_wb_data      <= wb_data_nxt;
            o_misalign     <= mis_nxt;
            o_bus_err      <= berr_nxt;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: scoreboard of expected MEM/WB results, one task per scenario.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        resetn;
    logic        i_mem_reg_write, i_mem_mem_write, i_mem_lsb, i_mem_lsh, i_mem_load_signext;
    logic [31:0] i_mem_data_mem, i_mem_pc4, i_mem_data_ex_wb;
    logic [4:0]  i_mem_rd;
    logic [1:0]  i_mem_select_data_wb;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_stall, o_wb_reg_write, o_misalign, o_bus_err;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stall_cnt, req_cnt;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .resetn(resetn),
        .i_mem_reg_write(i_mem_reg_write), .i_mem_mem_write(i_mem_mem_write),
        .i_mem_lsb(i_mem_lsb), .i_mem_lsh(i_mem_lsh), .i_mem_load_signext(i_mem_load_signext),
        .i_mem_data_mem(i_mem_data_mem), .i_mem_pc4(i_mem_pc4), .i_mem_data_ex_wb(i_mem_data_ex_wb),
        .i_mem_rd(i_mem_rd), .i_mem_select_data_wb(i_mem_select_data_wb),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_stall(o_stall), .o_wb_reg_write(o_wb_reg_write), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
    );

    task automatic set_op(input logic rw, input logic mw, input logic lb, input logic lh,
                          input logic sx, input logic [1:0] sel, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] pc4, input logic [4:0] rd);
        i_mem_reg_write = rw; i_mem_mem_write = mw; i_mem_lsb = lb; i_mem_lsh = lh;
        i_mem_load_signext = sx; i_mem_select_data_wb = sel; i_mem_data_ex_wb = addr;
        i_mem_data_mem = data; i_mem_pc4 = pc4; i_mem_rd = rd;
    endtask

    // Drives ncyc cycles from a negedge, acking in cycle ack_at (-1 = never); WB must hold bubbles until the last edge.
    task automatic exec(input int ack_at, input int ncyc, input logic [31:0] word);
        stall_cnt = 0;
        req_cnt   = 0;
        for (int c = 0; c < ncyc; c++) begin
            i_dmem_ack   = (c == ack_at);
            i_dmem_rdata = (c == ack_at) ? word : 32'hDEAD_BEEF;
            #1;
            if (o_stall)    stall_cnt++;
            if (o_dmem_req) req_cnt++;
            @(posedge clk);
            @(negedge clk);
            if (c != ncyc - 1) begin
                n_checks++;
                if (o_wb_reg_write !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_bubble cycle %0d: wb_reg_write=%b expected 0", c, o_wb_reg_write);
                end
            end
        end
        i_dmem_ack = 1'b0;
    endtask

    task automatic sb_pop(input string name);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            if (o_wb_reg_write !== e.we || o_misalign !== e.mis || o_bus_err !== e.berr ||
                (e.we && (o_wb_rd !== e.rd || o_wb_data !== e.data))) begin
                n_fail++;
                $display("FAIL %s: got we=%b rd=%0d data=%h mis=%b berr=%b expected we=%b rd=%0d data=%h mis=%b berr=%b",
                         name, o_wb_reg_write, o_wb_rd, o_wb_data, o_misalign, o_bus_err,
                         e.we, e.rd, e.data, e.mis, e.berr);
            end
        end
    endtask

    task automatic test_reset_state();
        set_op(1, 0, 0, 0, 0, 2'b01, 32'h0000_0100, 0, 0, 5'd2);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({o_dmem_req, o_stall, o_wb_reg_write, o_wb_rd, o_wb_data, o_misalign, o_bus_err} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b stall=%b we=%b rd=%0d data=%h mis=%b berr=%b expected all 0",
                     o_dmem_req, o_stall, o_wb_reg_write, o_wb_rd, o_wb_data, o_misalign, o_bus_err);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_zero_wait_lb();
        set_op(1, 0, 1, 0, 1, 2'b01, 32'h0000_1003, 0, 0, 5'd3);
        #1;
        n_checks++;
        if (o_dmem_addr !== 32'h0000_1000 || o_dmem_be !== 4'b1000 || o_dmem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_req: addr=%h be=%b we=%b expected 00001000 1000 0", o_dmem_addr, o_dmem_be, o_dmem_we);
        end
        sb_q.push_back('{we: 1'b1, rd: 5'd3, data: 32'hFFFF_FF80, mis: 1'b0, berr: 1'b0});
        exec(0, 1, 32'h80FF_FF12);
        n_checks++;
        if (stall_cnt != 0 || req_cnt != 1) begin
            n_fail++;
            $display("FAIL lb_stall: stall cycles=%0d req cycles=%0d expected 0 1", stall_cnt, req_cnt);
        end
        sb_pop("lb_zero_wait");
    endtask

    task automatic test_wait_lhu();
        set_op(1, 0, 0, 1, 0, 2'b01, 32'h0000_2002, 0, 0, 5'd7);
        #1;
        n_checks++;
        if (o_dmem_addr !== 32'h0000_2000 || o_dmem_be !== 4'b1100) begin
            n_fail++;
            $display("FAIL lhu_req: addr=%h be=%b expected 00002000 1100", o_dmem_addr, o_dmem_be);
        end
        sb_q.push_back('{we: 1'b1, rd: 5'd7, data: 32'h0000_BEEF, mis: 1'b0, berr: 1'b0});
        exec(3, 4, 32'hBEEF_1234);
        n_checks++;
        if (stall_cnt != 3 || req_cnt != 4) begin
            n_fail++;
            $display("FAIL lhu_stall: stall cycles=%0d req cycles=%0d expected 3 4", stall_cnt, req_cnt);
        end
        sb_pop("lhu_3_wait");
    endtask

    task automatic test_stores();
        logic [31:0] addrs [3] = '{32'h11, 32'h12, 32'h20};
        logic [31:0] datas [3] = '{32'h0000_00AB, 32'h1234_CDEF, 32'h1234_5678};
        logic [31:0] wds   [3] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'h1234_5678};
        logic [3:0]  bes   [3] = '{4'b0010, 4'b1100, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            set_op(1, 1, (i == 0), (i == 1), 0, 2'b00, addrs[i], datas[i], 0, 5'd5);
            #1;
            n_checks++;
            if (o_dmem_be !== bes[i] || o_dmem_wdata !== wds[i] || o_dmem_we !== 1'b1 ||
                o_dmem_addr !== {addrs[i][31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL store%0d_req: be=%b wdata=%h we=%b addr=%h expected %b %h 1 %h",
                         i, o_dmem_be, o_dmem_wdata, o_dmem_we, o_dmem_addr, bes[i], wds[i],
                         {addrs[i][31:2], 2'b00});
            end
            sb_q.push_back('{we: 1'b0, rd: 5'd5, data: 32'd0, mis: 1'b0, berr: 1'b0});
            exec(i % 2, (i % 2) + 1, 32'h5555_5555);
            sb_pop("store_no_wb");
        end
    endtask

    task automatic test_misaligned();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) set_op(1, 1, 0, 0, 0, 2'b00, 32'h6, 32'h1111_2222, 0, 5'd6);
            else        set_op(1, 0, 0, 1, 1, 2'b01, 32'h3, 0, 0, 5'd6);
            sb_q.push_back('{we: 1'b0, rd: 5'd6, data: 32'd0, mis: 1'b1, berr: 1'b0});
            exec(-1, 1, 0);
            n_checks++;
            if (req_cnt != 0 || stall_cnt != 0) begin
                n_fail++;
                $display("FAIL misalign%0d_req: req cycles=%0d stall cycles=%0d expected 0 0", i, req_cnt, stall_cnt);
            end
            sb_pop("misaligned");
        end
    endtask

    task automatic test_timeout();
        set_op(1, 0, 0, 0, 0, 2'b01, 32'h40, 0, 0, 5'd9);
        sb_q.push_back('{we: 1'b0, rd: 5'd9, data: 32'd0, mis: 1'b0, berr: 1'b1});
        exec(-1, 5, 0);
        n_checks++;
        if (stall_cnt != 5) begin
            n_fail++;
            $display("FAIL timeout_stall: stall cycles=%0d expected 5", stall_cnt);
        end
        sb_pop("timeout_bus_err");
        #1;
        n_checks++;
        if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_drop: req=%b stall=%b expected 0 0", o_dmem_req, o_stall);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (o_bus_err !== 1'b0 || o_wb_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: bus_err=%b we=%b expected 0 0", o_bus_err, o_wb_reg_write);
        end
        set_op(1, 0, 0, 0, 0, 2'b10, 32'h999, 0, 32'h104, 5'd1);
        sb_q.push_back('{we: 1'b1, rd: 5'd1, data: 32'h104, mis: 1'b0, berr: 1'b0});
        exec(-1, 1, 0);
        sb_pop("jal_after_timeout");
    endtask

    task automatic test_back_to_back();
        // ack held high with no request must be ignored
        logic [1:0]  sels [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
        logic [4:0]  rds  [4] = '{5'd10, 5'd11, 5'd12, 5'd0};
        logic [31:0] alus [4] = '{32'hA5A5_0001, 32'h0BAD_F00D, 32'h7777_0000, 32'h1234_0000};
        for (int i = 0; i < 4; i++) begin
            set_op(1, 0, 0, 0, 0, sels[i], alus[i], 0, 32'h0000_2004 + i, rds[i]);
            sb_q.push_back('{we: (rds[i] != 0), rd: rds[i],
                             data: (sels[i] == 2'b10) ? 32'h0000_2004 + i : alus[i],
                             mis: 1'b0, berr: 1'b0});
            exec(0, 1, 32'hFFFF_FFFF);
            n_checks++;
            if (stall_cnt != 0 || req_cnt != 0) begin
                n_fail++;
                $display("FAIL alu%0d_req: req cycles=%0d stall cycles=%0d expected 0 0", i, req_cnt, stall_cnt);
            end
            sb_pop("alu_back_to_back");
        end
    endtask

    task automatic test_reset_mid_wait();
        set_op(1, 0, 0, 0, 0, 2'b01, 32'h80, 0, 0, 5'd8);
        exec(-1, 2, 0);
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({o_dmem_req, o_stall, o_wb_reg_write, o_wb_rd, o_wb_data, o_misalign, o_bus_err} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: req=%b stall=%b we=%b rd=%0d data=%h expected all 0",
                     o_dmem_req, o_stall, o_wb_reg_write, o_wb_rd, o_wb_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        set_op(1, 0, 0, 0, 0, 2'b00, 32'h4444, 0, 0, 5'd4);
        sb_q.push_back('{we: 1'b1, rd: 5'd4, data: 32'h4444, mis: 1'b0, berr: 1'b0});
        exec(-1, 1, 0);
        sb_pop("after_reset_release");
    endtask

    initial begin
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'd0;
        test_reset_state();
        test_zero_wait_lb();
        test_wait_lhu();
        test_stores();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the RV32I pipeline, fed directly by the EX/MEM pipeline register. It performs:
- the data-memory transaction over a req/ack bus, with byte-lane and sign-extension handling;
- the write-back select;
- registration of the result into the MEM/WB register.

While a memory access is waiting for ack it raises a stall to freeze the upstream stages. A watchdog aborts accesses that never complete.

## Interface
- TIMEOUT, 16: max cycles (1..255) a request may stay unacknowledged before abort.
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- i_mem_reg_write, i_mem_mem_write, i_mem_lsb, i_mem_lsh, i_mem_load_signext  in  1 each  control from EX/MEM.
- i_mem_data_mem  in  32  store data (rs2).
- i_mem_pc4  in  32  PC+4.
- i_mem_data_ex_wb  in  32  ALU result; byte address for loads/stores.
- i_mem_rd  in  5  destination register.
- i_mem_select_data_wb  in  2  write-back source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- o_dmem_req  out  1  access request.
- o_dmem_we  out  1  1 = store.
- o_dmem_addr  out  32  word address, {addr[31:2],2'b00}.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  32  lane-replicated store data.
- i_dmem_ack  in  1  access complete; rdata valid in the same cycle.
- i_dmem_rdata  in  32  read word.
- o_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- o_wb_reg_write  out  1  registered write enable.
- o_wb_rd  out  5  registered destination.
- o_wb_data  out  32  registered write-back data.
- o_misalign  out  1  registered one-cycle pulse: misaligned access dropped.
- o_bus_err  out  1  registered one-cycle pulse: access timed out.

## Operation

**Classification**
- mem_op = mem_write | (select_data_wb==01).
- Size: lsb=byte; lsh=half (lsb takes priority if both set); otherwise word.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.

**Byte enables and store data**
- Byte: be=4'b0001<<addr[1:0]; wdata={4{data[7:0]}}.
- Half: be=addr[1] ? 4'b1100 : 4'b0011; wdata={2{data[15:0]}}.
- Word: be=4'b1111; wdata=data.
- be is also driven for loads; memory ignores it when we=0.

**Load extraction**
- Byte: b=rdata>>(8*addr[1:0]).
- Half: h=rdata>>(16*addr[1]).
- Extension: sign-extend when load_signext=1, else zero-extend. Word passes through unchanged.

**FSM states: IDLE, WAIT**
- IDLE, non-mem op:
  - req=0, stall=0.
  - Next edge: WB register loads reg_write, rd and the ALU or PC+4 data.
- IDLE, mem op, misaligned:
  - req=0, stall=0.
  - Next edge: o_misalign=1, o_wb_reg_write=0.
- IDLE, aligned mem op, ack=1 (zero-wait):
  - req=1, stall=0.
  - Next edge: WB register loads the load data; stays IDLE.
- IDLE, aligned mem op, ack=0:
  - req=1, stall=1.
  - Next edge: go to WAIT, cnt=1.
- WAIT:
  - req=1 with all request fields held; inputs are stable because upstream is stalled.
  - stall=!ack.
  - While waiting, the WB register loads a bubble (reg_write=0).
- WAIT, ack=1:
  - Next edge: WB register loads the result; go to IDLE.
- WAIT, ack=0 and cnt==TIMEOUT:
  - stall=1 this cycle.
  - Next edge: o_bus_err=1, o_wb_reg_write=0, req drops, go to IDLE.
  - The instruction is discarded; upstream advances in the following cycle.
- WAIT, otherwise: cnt increments; cnt is 8 bits and saturates, never wraps.

**Write-back rules**
- o_wb_reg_write = reg_write & (rd≠0) & !misalign & !bus_err.
- Stores never write back, whatever reg_write is.

## Timing
- Reset (async, resetn=0): state=IDLE, cnt=0, and every registered output is 0 (o_wb_reg_write, o_wb_rd, o_wb_data, o_misalign, o_bus_err).
- While resetn=0, o_stall=0 and o_dmem_req=0.
- Reset mid-WAIT abandons the access immediately; req drops asynchronously.
- Request and stall outputs are combinational from inputs, state and ack.
- Latency: result appears in the WB register 1 cycle after the ack cycle, or 1 cycle after entry for non-mem ops.
- Stall length = cycles without ack.
- ack in IDLE with req=0 is ignored.

## Test plan
- **Reset:** resetn low mid-WAIT → all outputs 0, req=0, state IDLE; first edge after release takes new input.
- **Zero-wait lb:** addr=0x1003, signext=1, rdata=0x80FF_FF12, ack held 1 → stall never 1; next cycle o_wb_data=0xFFFF_FF80, reg_write=1.
- **3-wait lhu:** addr=0x2002, signext=0, rdata=0xBEEF_1234 with ack on 4th cycle → stall=1 for 3 cycles, bubbles in WB; then o_wb_data=0x0000_BEEF.
- **Stores:** sb addr=0x11, data=0xAB → be=0010, wdata=0xABAB_ABAB, addr=0x10. sh addr=0x12 → be=1100. sw → be=1111. No WB write in any case.
- **Misaligned:** sw addr=0x6 → no req, o_misalign pulse, reg_write=0. lh addr=0x3 → same.
- **Timeout:** TIMEOUT=4, lw with no ack → stall high 5 cycles (entry + 4 WAIT), then o_bus_err pulse, req=0. Next op (jal, select=10, pc4=0x104, rd=1) → o_wb_data=0x104.
